// File: rtl/mmcm_reconfig_seq_if.sv
// DRP bus between the reconfiguration sequencer (master) and the MMCM DRP port (slave).
interface mmcm_reconfig_seq_if;
   logic [6:0]  drp_daddr;
   logic        drp_den;
   logic        drp_dwe;
   logic [15:0] drp_di;
   logic [15:0] drp_do;
   logic        drp_drdy;

   modport master (
      output drp_daddr, drp_den, drp_dwe, drp_di,
      input  drp_do, drp_drdy
   );

   modport slave (
      input  drp_daddr, drp_den, drp_dwe, drp_di,
      output drp_do, drp_drdy
   );
endinterface

// File: rtl/mmcm_reconfig_seq.sv
// MMCM DRP reconfiguration sequencer: hold reset, read-modify-write each register, release, lock.
// Defining MMCM_WATCHDOG_EN adds DRDY and lock timeouts that raise a sticky err.
module mmcm_reconfig_seq #(
   parameter int unsigned MODE_W       = 2,
   parameter int unsigned NUM_REGS     = 23,
   parameter int unsigned IDX_W        = 5,
   parameter int unsigned DRDY_TIMEOUT = 64,
   parameter int unsigned LOCK_TIMEOUT = 65536
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [MODE_W-1:0]   mode_sel_i,
   input  logic                mode_req_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o,
   output logic [MODE_W-1:0]   cur_mode_o,
   output logic                out_en_o,
   output logic [MODE_W-1:0]   cfg_mode_o,
   output logic [IDX_W-1:0]    cfg_idx_o,
   input  logic [6:0]          cfg_addr_i,
   input  logic [15:0]         cfg_mask_i,
   input  logic [15:0]         cfg_data_i,
   mmcm_reconfig_seq_if.master drp,
   output logic                mmcm_rst_o,
   input  logic                mmcm_locked_i
);

   if (NUM_REGS < 1 || (2 ** IDX_W) < NUM_REGS || DRDY_TIMEOUT < 1 || LOCK_TIMEOUT < 1)
   begin : gen_param_check
      $error("mmcm_reconfig_seq: invalid parameter set");
   end

   typedef enum logic [3:0] {
      StIdle,
      StRstAssert,
      StRdReq,
      StRdWait,
      StWrReq,
      StWrWait,
      StNext,
      StRelease,
      StLockWait,
      StDone
   } state_e;

   state_e              state_d, state_q;
   logic [MODE_W-1:0]   cur_mode_d, cur_mode_q;
   logic [MODE_W-1:0]   cfg_mode_d, cfg_mode_q;
   logic [IDX_W-1:0]    cfg_idx_d, cfg_idx_q;
   logic [6:0]          addr_d, addr_q;
   logic [15:0]         mask_d, mask_q;
   logic [15:0]         data_d, data_q;
   logic [15:0]         rdata_d, rdata_q;
   logic                out_en_d, out_en_q;
   logic                mmcm_rst_d, mmcm_rst_q;
   logic [1:0]          lock_sync_q;
   logic                lock_s;
   logic                last_idx;
   logic                err_d, err_q;

   assign lock_s   = lock_sync_q[1];
   assign last_idx = (cfg_idx_q == IDX_W'(NUM_REGS - 1));

`ifdef MMCM_WATCHDOG_EN
   localparam int unsigned WdMax = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
   localparam int unsigned WdW   = $clog2(WdMax + 1);

   logic [WdW-1:0] wd_cnt_d, wd_cnt_q;
   logic           wd_expire;

   // The counter restarts on every state entry, so each wait gets its own full budget.
   always_comb begin
      wd_expire = 1'b0;
      unique case (state_q)
         StRdWait, StWrWait: wd_expire = (wd_cnt_q == WdW'(DRDY_TIMEOUT - 1));
         StLockWait:         wd_expire = (wd_cnt_q == WdW'(LOCK_TIMEOUT - 1));
         default:            wd_expire = 1'b0;
      endcase
   end

   always_comb begin
      wd_cnt_d = '0;
      if ((state_d == state_q) &&
          (state_q inside {StRdWait, StWrWait, StLockWait})) begin
         wd_cnt_d = wd_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         err_q    <= err_d;
      end
   end
`else
   assign err_q = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cur_mode_q  <= '0;
         cfg_mode_q  <= '0;
         cfg_idx_q   <= '0;
         addr_q      <= '0;
         mask_q      <= '0;
         data_q      <= '0;
         rdata_q     <= '0;
         out_en_q    <= 1'b0;
         mmcm_rst_q  <= 1'b0;
         lock_sync_q <= 2'b00;
      end else begin
         state_q     <= state_d;
         cur_mode_q  <= cur_mode_d;
         cfg_mode_q  <= cfg_mode_d;
         cfg_idx_q   <= cfg_idx_d;
         addr_q      <= addr_d;
         mask_q      <= mask_d;
         data_q      <= data_d;
         rdata_q     <= rdata_d;
         out_en_q    <= out_en_d;
         mmcm_rst_q  <= mmcm_rst_d;
         lock_sync_q <= {lock_sync_q[0], mmcm_locked_i};
      end
   end

   always_comb begin
      state_d    = state_q;
      cur_mode_d = cur_mode_q;
      cfg_mode_d = cfg_mode_q;
      cfg_idx_d  = cfg_idx_q;
      addr_d     = addr_q;
      mask_d     = mask_q;
      data_d     = data_q;
      rdata_d    = rdata_q;
      err_d      = err_q;

      unique case (state_q)
         StIdle: begin
            if (mode_req_i) begin
               // A pending error forces a full rerun even for the current mode.
               if ((mode_sel_i == cur_mode_q) && !err_q) begin
                  state_d = StDone;
               end else begin
                  cfg_mode_d = mode_sel_i;
                  cfg_idx_d  = '0;
                  err_d      = 1'b0;
                  state_d    = StRstAssert;
               end
            end
         end
         StRstAssert: state_d = StRdReq;
         StRdReq: begin
            addr_d  = cfg_addr_i;
            mask_d  = cfg_mask_i;
            data_d  = cfg_data_i;
            state_d = StRdWait;
         end
         StRdWait: begin
            if (drp.drp_drdy) begin
               rdata_d = drp.drp_do;
               state_d = StWrReq;
            end
`ifdef MMCM_WATCHDOG_EN
            else if (wd_expire) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
`endif
         end
         StWrReq: state_d = StWrWait;
         StWrWait: begin
            if (drp.drp_drdy) begin
               state_d = StNext;
            end
`ifdef MMCM_WATCHDOG_EN
            else if (wd_expire) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
`endif
         end
         StNext: begin
            if (last_idx) begin
               state_d = StRelease;
            end else begin
               cfg_idx_d = cfg_idx_q + 1'b1;
               state_d   = StRdReq;
            end
         end
         StRelease: state_d = StLockWait;
         StLockWait: begin
            if (lock_s) begin
               cur_mode_d = cfg_mode_q;
               state_d    = StDone;
            end
`ifdef MMCM_WATCHDOG_EN
            else if (wd_expire) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
`endif
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Registered from the next state so both rise/fall on the same edge as the transition.
      mmcm_rst_d = state_d inside {StRstAssert, StRdReq, StRdWait, StWrReq, StWrWait, StNext};
      out_en_d   = (state_d == StIdle) && lock_s && !err_d;
   end

   always_comb begin
      busy_o        = (state_q != StIdle);
      done_o        = (state_q == StDone);
      drp.drp_den   = 1'b0;
      drp.drp_dwe   = 1'b0;
      drp.drp_daddr = '0;
      drp.drp_di    = '0;
      unique case (state_q)
         StRdReq: begin
            drp.drp_den   = 1'b1;
            drp.drp_daddr = cfg_addr_i;
         end
         StWrReq: begin
            drp.drp_den   = 1'b1;
            drp.drp_dwe   = 1'b1;
            drp.drp_daddr = addr_q;
            drp.drp_di    = (rdata_q & mask_q) | (data_q & ~mask_q);
         end
         default: ;
      endcase
   end

   assign err_o      = err_q;
   assign cur_mode_o = cur_mode_q;
   assign out_en_o   = out_en_q;
   assign cfg_mode_o = cfg_mode_q;
   assign cfg_idx_o  = cfg_idx_q;
   assign mmcm_rst_o = mmcm_rst_q;

endmodule

// File: tb/tb_mmcm_reconfig_seq.sv
// Self-checking bench: DRP register-file/lock model plus a reference of the expected write stream.
module tb_mmcm_reconfig_seq;
   localparam int NUM_REGS = 23;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  mode_sel = 2'd0;
   logic        mode_req = 1'b0;
   logic        busy, done, err, out_en, mmcm_rst;
   logic [1:0]  cur_mode, cfg_mode;
   logic [4:0]  cfg_idx;
   logic [6:0]  cfg_addr;
   logic [15:0] cfg_mask, cfg_data;
   logic        mmcm_locked = 1'b1;

   logic [6:0]  t_addr [4][32];
   logic [15:0] t_mask [4][32];
   logic [15:0] t_data [4][32];
   logic [15:0] mem [128];

   int n_vec = 0, n_err = 0;
   int cyc = 0, den_cnt = 0, rd_cnt = 0, wr_cnt = 0, viol = 0;
   int rst_hi = 0, rel_cyc = 0, busy_cyc = 0, done_cnt = 0, done_cyc = 0, req_cyc = 0;
   int rlat = 2, wlat = 2, lock_len = 4, resp_cnt = 0, lock_cnt = 0;
   bit stuck = 1'b0, prev_den = 1'b0;
   logic [15:0] resp_data = 16'h0;
   logic [22:0] wq [$];
   int exp_cur = 0;

   mmcm_reconfig_seq_if drp_bus ();

   assign cfg_addr = t_addr[cfg_mode][cfg_idx];
   assign cfg_mask = t_mask[cfg_mode][cfg_idx];
   assign cfg_data = t_data[cfg_mode][cfg_idx];

   mmcm_reconfig_seq dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mode_sel_i    (mode_sel),
      .mode_req_i    (mode_req),
      .busy_o        (busy),
      .done_o        (done),
      .err_o         (err),
      .cur_mode_o    (cur_mode),
      .out_en_o      (out_en),
      .cfg_mode_o    (cfg_mode),
      .cfg_idx_o     (cfg_idx),
      .cfg_addr_i    (cfg_addr),
      .cfg_mask_i    (cfg_mask),
      .cfg_data_i    (cfg_data),
      .drp           (drp_bus),
      .mmcm_rst_o    (mmcm_rst),
      .mmcm_locked_i (mmcm_locked)
   );

   always #5 clk = ~clk;

   // Observation and DRP/MMCM behaviour, all sampled mid-cycle.
   always @(negedge clk) begin
      cyc++;
      if (drp_bus.drp_den) begin
         den_cnt++;
         if (prev_den || !mmcm_rst) viol++;
         if (drp_bus.drp_dwe) begin
            wr_cnt++;
            wq.push_back({drp_bus.drp_daddr, drp_bus.drp_di});
            mem[drp_bus.drp_daddr] = drp_bus.drp_di;
         end else begin
            rd_cnt++;
            resp_data = mem[drp_bus.drp_daddr];
         end
      end
      if (drp_bus.drp_dwe && !drp_bus.drp_den) viol++;
      prev_den = drp_bus.drp_den;
      if (mmcm_rst) rst_hi++;
      if (busy && !mmcm_rst) rel_cyc++;
      if (busy) busy_cyc++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (mode_req && !busy) req_cyc = cyc;

      drp_bus.drp_drdy = 1'b0;
      if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0 && !stuck) begin
            drp_bus.drp_drdy = 1'b1;
            drp_bus.drp_do   = resp_data;
         end
      end
      if (drp_bus.drp_den) resp_cnt = drp_bus.drp_dwe ? wlat : rlat;

      if (mmcm_rst) begin
         mmcm_locked = 1'b0;
         lock_cnt    = lock_len;
      end else if (lock_cnt > 0) begin
         lock_cnt--;
         if (lock_cnt == 0) mmcm_locked = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_counts();
      den_cnt = 0; rd_cnt = 0; wr_cnt = 0; viol = 0; rst_hi = 0; rel_cyc = 0;
      busy_cyc = 0; done_cnt = 0; done_cyc = 0; req_cyc = 0;
      wq.delete();
   endtask

   task automatic request(input int m);
      @(posedge clk); #1;
      mode_sel = 2'(m);
      mode_req = 1'b1;
      @(posedge clk); #1;
      mode_req = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      for (int k = 0; k < bound; k++) begin
         @(posedge clk); #1;
         if (done_cnt != 0 && !busy) break;
      end
   endtask

   task automatic randomize_mode(input int m);
      for (int i = 0; i < 32; i++) begin
         t_addr[m][i] = 7'($urandom_range(0, 127));
         t_mask[m][i] = 16'($urandom);
         t_data[m][i] = 16'($urandom);
      end
   endtask

   task automatic chk_reset_vals(input string p);
      chk({p, "_busy"},     32'(busy), 0);
      chk({p, "_done"},     32'(done), 0);
      chk({p, "_err"},      32'(err), 0);
      chk({p, "_cur_mode"}, 32'(cur_mode), 0);
      chk({p, "_out_en"},   32'(out_en), 0);
      chk({p, "_cfg_mode"}, 32'(cfg_mode), 0);
      chk({p, "_cfg_idx"},  32'(cfg_idx), 0);
      chk({p, "_den"},      32'(drp_bus.drp_den), 0);
      chk({p, "_dwe"},      32'(drp_bus.drp_dwe), 0);
      chk({p, "_daddr"},    32'(drp_bus.drp_daddr), 0);
      chk({p, "_di"},       32'(drp_bus.drp_di), 0);
      chk({p, "_mmcm_rst"}, 32'(mmcm_rst), 0);
   endtask

   // Full retune: expected writes come from applying each table entry in order to a memory copy.
   task automatic run_full(input int m, input int rl, input int wl, input int lk, input bit poke);
      logic [15:0] refm [128];
      logic [22:0] eq [$];
      logic [15:0] nv;
      logic [6:0]  a;
      logic [22:0] got;
      int diffs;
      for (int i = 0; i < 128; i++) refm[i] = mem[i];
      for (int i = 0; i < NUM_REGS; i++) begin
         a       = t_addr[m][i];
         nv      = (refm[a] & t_mask[m][i]) | (t_data[m][i] & ~t_mask[m][i]);
         refm[a] = nv;
         eq.push_back({a, nv});
      end
      rlat = rl; wlat = wl; lock_len = lk;
      clear_counts();
      request(m);
      if (poke) begin
         for (int k = 0; k < 2000 && rd_cnt < 3; k++) begin
            @(posedge clk); #1;
         end
         request((m + 1) % 4);
         chk("poke_cfg_mode", 32'(cfg_mode), 32'(m));
         chk("poke_busy", 32'(busy), 1);
      end
      wait_done(5000);
      chk("done_cnt", 32'(done_cnt), 1);
      chk("den_cnt", 32'(den_cnt), 32'(2 * NUM_REGS));
      chk("rd_cnt", 32'(rd_cnt), 32'(NUM_REGS));
      chk("wr_cnt", 32'(wr_cnt), 32'(NUM_REGS));
      for (int i = 0; i < NUM_REGS; i++) begin
         got = (i < wq.size()) ? wq[i] : 23'h0;
         chk($sformatf("write%0d", i), 32'(got), 32'(eq[i]));
      end
      diffs = 0;
      for (int i = 0; i < 128; i++) if (mem[i] !== refm[i]) diffs++;
      chk("mem_diffs", 32'(diffs), 0);
      chk("cur_mode", 32'(cur_mode), 32'(m));
      chk("rst_hi_cycles", 32'(rst_hi), 32'(1 + NUM_REGS * (3 + rl + wl)));
      chk("lock_wait_range", 32'((rel_cyc - 2 >= lk) && (rel_cyc - 2 <= lk + 2)), 1);
      chk("busy_cycles", 32'(busy_cyc), 32'(rst_hi + rel_cyc));
      chk("protocol", 32'(viol), 0);
      chk("err_clear", 32'(err), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("out_en_after", 32'(out_en), 1);
      chk("mmcm_rst_after", 32'(mmcm_rst), 0);
      chk("busy_after", 32'(busy), 0);
   endtask

   initial begin
      int m;
      int oe_wait;
      drp_bus.drp_do   = 16'h0;
      drp_bus.drp_drdy = 1'b0;
      for (int k = 0; k < 4; k++) randomize_mode(k);
      for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);

      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      rst_n = 1'b1;
      oe_wait = 99;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         if (out_en) begin
            oe_wait = k;
            break;
         end
      end
      chk("out_en_reset_lat", 32'(oe_wait <= 3), 1);
      chk("idle_busy", 32'(busy), 0);

      t_addr[1][0] = 7'h10;
      t_mask[1][0] = 16'hFF00;
      t_data[1][0] = 16'h1234;
      mem[7'h10]   = 16'hA5A5;
      run_full(1, 2, 2, 4, 1'b0);
      chk("a5a5_di", 32'(wq.size() > 0 ? wq[0][15:0] : 16'h0), 32'h0000A534);
      exp_cur = 1;

      clear_counts();
      request(1);
      repeat (3) @(posedge clk);
      #1;
      chk("same_den", 32'(den_cnt), 0);
      chk("same_done", 32'(done_cnt), 1);
      chk("same_done_lat", 32'((done_cyc - req_cyc >= 1) && (done_cyc - req_cyc <= 2)), 1);
      chk("same_cur", 32'(cur_mode), 1);
      chk("same_busy", 32'(busy), 0);

      run_full(2, 1, 3, 3, 1'b1);
      exp_cur = 2;

      clear_counts();
      rlat = 2; wlat = 2;
      request(3);
      for (int k = 0; k < 2000 && rd_cnt < 5; k++) begin
         @(posedge clk); #1;
      end
      chk("midrst_started", 32'(rd_cnt >= 5), 1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_reset_vals("postrst");
      oe_wait = 99;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
         if (out_en) begin
            oe_wait = k;
            break;
         end
      end
      chk("postrst_out_en", 32'(out_en), 1);
      exp_cur = 0;

      for (int r = 0; r < 4; r++) begin
         do m = $urandom_range(0, 3); while (m == exp_cur);
         randomize_mode(m);
         run_full(m, $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 6), 1'b0);
         exp_cur = m;
      end

`ifdef MMCM_WATCHDOG_EN
      stuck = 1'b1;
      clear_counts();
      request(exp_cur ^ 1);
      for (int k = 0; k < 300; k++) begin
         @(posedge clk); #1;
         if (!busy) break;
      end
      chk("wd_err", 32'(err), 1);
      chk("wd_busy", 32'(busy), 0);
      chk("wd_out_en", 32'(out_en), 0);
      chk("wd_done", 32'(done_cnt), 0);
      chk("wd_mmcm_rst", 32'(mmcm_rst), 0);
      chk("wd_cur_mode", 32'(cur_mode), 32'(exp_cur));
      chk("wd_busy_cycles", 32'((busy_cyc >= 64) && (busy_cyc <= 68)), 1);
      stuck = 1'b0;
      run_full(exp_cur, 2, 2, 3, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mmcm_reconfig_seq.md
# mmcm_reconfig_seq

Sequencer that retunes the HDMI clocking MMCM (pixel clock and 5x serializer clock) between video modes through its Dynamic Reconfiguration Port. On a mode request it holds the MMCM in reset, performs a read-modify-write of every DRP register for the selected mode, releases reset, and waits for lock. It then re-enables the DVI transmitter domain. It runs on the DRP clock and sits beside the clock wrapper, owning the MMCM `RST`/`D*` pins and the transmitter enable.

## Interface
- `MODE_W`, 2: width of the mode index.
- `NUM_REGS`, 23: DRP writes per mode; must be ≥ 1.
- `IDX_W`, 5: width of the register index; 2^`IDX_W` ≥ `NUM_REGS`.
- `DRDY_TIMEOUT`, 64: cycles allowed for `drp_drdy` (watchdog build only).
- `LOCK_TIMEOUT`, 65536: cycles allowed for lock after release (watchdog build only).

Ports:
- `clk` in 1: DRP clock; also drives the MMCM `DCLK`.
- `rst_n` in 1: asynchronous, active-low reset.
- `mode_sel` in `MODE_W`: requested mode, sampled with `mode_req`.
- `mode_req` in 1: start request; honoured only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on completion.
- `err` out 1: sticky watchdog error; cleared by the next accepted `mode_req`.
- `cur_mode` out `MODE_W`: mode currently programmed.
- `out_en` out 1: transmitter enable.
- `cfg_mode` out `MODE_W`: mode index to the external table.
- `cfg_idx` out `IDX_W`: register index to the external table.
- `cfg_addr` in 7, `cfg_mask` in 16, `cfg_data` in 16: table entry, combinational from `cfg_mode`/`cfg_idx`.
- `drp_daddr` out 7, `drp_den` out 1, `drp_dwe` out 1, `drp_di` out 16: DRP request.
- `drp_do` in 16, `drp_drdy` in 1: DRP response.
- `mmcm_rst` out 1: MMCM reset, active high.
- `mmcm_locked` in 1: MMCM `LOCKED`, asynchronous; a 2-flop synchronizer is internal.

## Operation
- States: IDLE, RST_ASSERT, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT, RELEASE, LOCK_WAIT, DONE.
- Reset values: all outputs 0, state IDLE, `cur_mode`=0 (the bitstream default mode), `cfg_idx`=0, synchronizer cleared.
- IDLE, `mode_req`=1, `mode_sel`==`cur_mode`, `err`=0: no DRP traffic; go to DONE next cycle.
- IDLE, `mode_req`=1 otherwise:
  - latch `mode_sel` into `cfg_mode`, set `cfg_idx`=0, clear `err`;
  - register `out_en`=0 and `mmcm_rst`=1; go to RST_ASSERT.
- RST_ASSERT: one cycle; then RD_REQ.
- RD_REQ:
  - `drp_den`=1, `drp_dwe`=0, `drp_daddr`=`cfg_addr`;
  - latch `cfg_addr`, `cfg_mask` and `cfg_data` into internal registers; then RD_WAIT.
- RD_WAIT: on `drp_drdy`, capture `drp_do`; then WR_REQ.
- WR_REQ:
  - `drp_den`=1, `drp_dwe`=1, `drp_daddr`=latched address;
  - `drp_di`=(captured_do & mask) | (data & ~mask); then WR_WAIT.
- WR_WAIT: on `drp_drdy`, go to NEXT.
- NEXT:
  - if `cfg_idx`==`NUM_REGS`-1, go to RELEASE with `cfg_idx` left unchanged;
  - else increment `cfg_idx` and go to RD_REQ.
- RELEASE: `mmcm_rst`=0; then LOCK_WAIT.
- LOCK_WAIT: on synchronized locked=1, set `cur_mode`=`cfg_mode`; then DONE.
- DONE: `done`=1 for one cycle; then IDLE.
- `out_en` is registered: (state==IDLE) & synchronized locked & ~`err`. It therefore falls within 3 cycles of `mmcm_locked` dropping while in IDLE.
- `mode_req` while `busy`: ignored, not queued.
- `drp_drdy` outside RD_WAIT/WR_WAIT: ignored.
- `rst_n` low mid-sequence: immediate return to reset values, `mmcm_rst` drops. The MMCM may be left half-programmed; `cur_mode`=0 is then stale, and software must issue a mode request with a mode ≠ 0 or re-run.

## Timing
- `drp_den` is high exactly one cycle per access.
- `drp_dwe` is high only together with `drp_den` in WR_REQ.
- `drp_daddr`/`drp_di` are stable while `drp_den` is high.
- `mmcm_rst` rises at least one cycle before the first `drp_den` and falls one cycle after the last write's `drp_drdy`.
- Per register, with read latency r and write latency w: 3 + r + w cycles, where r,w ≥ 1 is the cycle count from DEN to DRDY.
- Total for a full sequence: 2 + `NUM_REGS`·(3+r+w) + 1 + lock-wait + 1 (DONE).
- Same-mode request: `done` 2 cycles after `mode_req`.

## Configuration
- `MMCM_WATCHDOG_EN` defined:
  - a counter runs in RD_WAIT/WR_WAIT, and a timeout at `DRDY_TIMEOUT` cycles sets `err`, drops `mmcm_rst`, and returns to IDLE with no `done`;
  - a timeout in LOCK_WAIT at `LOCK_TIMEOUT` cycles does the same, and `cur_mode` is not updated.
- Undefined: no counters; the block waits indefinitely and `err` is constant 0.

## Test plan
- Reset, then a DRP model with r=w=2 holds `mmcm_locked`=1 → `out_en`=1 within 3 cycles and `busy`=0.
- `mode_sel`=1 request, `NUM_REGS`=23 → 23 read/write pairs with `mmcm_rst` high throughout. Then `done`, `cur_mode`=1, `out_en`=1 after lock; total cycles per formula.
- Table entry: do=0xA5A5, mask=0xFF00, data=0x1234 → `drp_di`=0xA534.
- Request with `mode_sel`==`cur_mode` → no `drp_den`; `done` 2 cycles later.
- `mode_req` pulsed mid-sequence, then `rst_n` pulsed mid-sequence → first ignored; after reset all outputs are at reset values and `mmcm_rst`=0.
- With `MMCM_WATCHDOG_EN` and `drp_drdy` stuck low → after 64 cycles `err`=1, `busy`=0, `out_en`=0, no `done`. The next request clears `err`.
